issue_scheduler: RTL and testbench

//  Out-of-order issue queue between dual-issue decode and execute. Accepts up to two task_t per cycle
//  (slot 0 older than slot 1), holds them in a collapsing age-ordered queue and tracks in-flight rd via
//  a register scoreboard. Issues the oldest hazard-free task per cycle into a registered valid/ready port.

---
 rtl/issue_scheduler_pkg.sv | 56 +++++
 rtl/issue_scheduler_if.sv | 34 +++
 rtl/issue_scheduler_scoreboard.sv | 57 +++++
 rtl/issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_issue_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types and helpers for the issue scheduler.
//   task_t      : decoded task (opcode, register operands with use flags, tag)
//   opcode_t    : task class; LOAD/STORE are kept in program order
//   ISSUE_DEPTH : default queue depth
//   task_writes / task_reads : register match helpers with x0 and *_used masking
//   older_blocks : true when an older queued task forbids a younger one from issuing
package issue_scheduler_pkg;

  localparam int unsigned ISSUE_DEPTH = 8;
  localparam int unsigned REG_ADDR_W  = 5;

  typedef enum logic [2:0] {
    OpAlu,
    OpAluImm,
    OpLoad,
    OpStore,
    OpBranch
  } opcode_t;

  typedef struct packed {
    opcode_t                opcode;
    logic [REG_ADDR_W-1:0]  rd;
    logic [REG_ADDR_W-1:0]  rs1;
    logic [REG_ADDR_W-1:0]  rs2;
    logic                   rd_used;
    logic                   rs1_used;
    logic                   rs2_used;
    logic [7:0]             tag;
  } task_t;

  // x0 is never a real dependency, so any match against it is false.
  function automatic logic task_writes(task_t t, logic [REG_ADDR_W-1:0] r);
    return t.rd_used && (t.rd == r) && (r != '0);
  endfunction

  function automatic logic task_reads(task_t t, logic [REG_ADDR_W-1:0] r);
    return (r != '0) && ((t.rs1_used && (t.rs1 == r)) || (t.rs2_used && (t.rs2 == r)));
  endfunction

  function automatic logic is_mem(task_t t);
    return (t.opcode == OpLoad) || (t.opcode == OpStore);
  endfunction

  // RAW, WAW and WAR against an older in-queue task, plus memory ordering.
  function automatic logic older_blocks(task_t older, task_t young);
    logic hit;
    hit = 1'b0;
    if (young.rs1_used && task_writes(older, young.rs1)) hit = 1'b1;
    if (young.rs2_used && task_writes(older, young.rs2)) hit = 1'b1;
    if (young.rd_used && task_writes(older, young.rd)) hit = 1'b1;
    if (young.rd_used && task_reads(older, young.rd)) hit = 1'b1;
    if (is_mem(young) && is_mem(older)) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Bus bundle for the issue scheduler.
//   master : decode/execute/writeback side (drives tasks, issue_ready, wb, flush)
//   slave  : the scheduler (drives enq_ready, issue_task, issue_valid, count)
interface issue_scheduler_if
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  task_t                 task_0;
  task_t                 task_1;
  logic                  valid_0;
  logic                  valid_1;
  logic                  enq_ready;
  task_t                 issue_task;
  logic                  issue_valid;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic                  flush;
  logic [CNT_W-1:0]      count;

  modport master (
    output task_0, task_1, valid_0, valid_1, issue_ready, wb_valid, wb_rd_addr, flush,
    input  enq_ready, issue_task, issue_valid, count
  );

  modport slave (
    input  task_0, task_1, valid_0, valid_1, issue_ready, wb_valid, wb_rd_addr, flush,
    output enq_ready, issue_task, issue_valid, count
  );

endinterface

// File: rtl/issue_scheduler_scoreboard.sv
// Register busy tracker for in-flight destinations.
//   clk, rst_n             : clock, async active-low reset
//   flush                  : synchronous clear of every busy bit (overrides set/clear)
//   set_valid, set_addr    : mark a register busy at issue
//   clr_valid, clr_addr    : writeback clears a register; set wins on a collision
//   rs1/rs2/rd_addr[i]     : lookup addresses, one triple per queue entry
//   rs1/rs2/rd_busy[i]     : combinational busy result for each lookup
module issue_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_LOOKUP = ISSUE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr [NUM_LOOKUP],
  input  logic [REG_ADDR_W-1:0] rs2_addr [NUM_LOOKUP],
  input  logic [REG_ADDR_W-1:0] rd_addr  [NUM_LOOKUP],
  output logic [NUM_LOOKUP-1:0] rs1_busy,
  output logic [NUM_LOOKUP-1:0] rs2_busy,
  output logic [NUM_LOOKUP-1:0] rd_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so an issue and a writeback of one register leave it busy.
    if (set_valid) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_LOOKUP; i++) begin
      rs1_busy[i] = busy_q[rs1_addr[i]];
      rs2_busy[i] = busy_q[rs2_addr[i]];
      rd_busy[i]  = busy_q[rd_addr[i]];
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue between dual-issue decode and execute.
//   clk, rst_n : clock, async active-low reset
//   bus        : issue_scheduler_if slave port
//                task_0/valid_0 (older), task_1/valid_1 (younger), enq_ready,
//                issue_task/issue_valid/issue_ready (registered output),
//                wb_valid/wb_rd_addr (busy clear), flush, count
// Entries live in a collapsing array, index 0 oldest; the oldest hazard-free entry
// moves into the issue register and younger entries shift down behind it.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH    = ISSUE_DEPTH,
  parameter int unsigned NUM_REGS = 32
) (
  input logic               clk,
  input logic               rst_n,
  issue_scheduler_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  task_t            ent_q [DEPTH];
  task_t            ent_d [DEPTH];
  task_t            shifted [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  task_t            issue_task_q;
  logic             issue_valid_q;

  logic             enq_ready;
  logic [DEPTH-1:0] elig;
  logic             any_elig;
  int unsigned      sel_idx;
  task_t            sel_task;
  logic             issue_load;
  int unsigned      keep, pos0, pos1;

  logic [REG_ADDR_W-1:0] rs1_addr [DEPTH];
  logic [REG_ADDR_W-1:0] rs2_addr [DEPTH];
  logic [REG_ADDR_W-1:0] rd_addr  [DEPTH];
  logic [DEPTH-1:0]      rs1_busy, rs2_busy, rd_busy;

  // Room for a full pair, judged on registered occupancy only.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rs1_addr[i] = ent_q[i].rs1;
      rs2_addr[i] = ent_q[i].rs2;
      rd_addr[i]  = ent_q[i].rd;
    end
  end

  issue_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .NUM_LOOKUP (DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .set_valid (issue_load && sel_task.rd_used),
    .set_addr  (sel_task.rd),
    .clr_valid (bus.wb_valid),
    .clr_addr  (bus.wb_rd_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_busy   (rd_busy)
  );

  // Eligibility matrix: entry i is vetoed by in-flight registers or by any older entry j.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      elig[i] = (CNT_W'(i) < count_q)
                && !(ent_q[i].rs1_used && rs1_busy[i])
                && !(ent_q[i].rs2_used && rs2_busy[i])
                && !(ent_q[i].rd_used && rd_busy[i]);
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if ((j < i) && older_blocks(ent_q[j], ent_q[i])) elig[i] = 1'b0;
      end
    end
  end

  always_comb begin
    any_elig = 1'b0;
    sel_idx  = 0;
    sel_task = ent_q[0];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (elig[i] && !any_elig) begin
        any_elig = 1'b1;
        sel_idx  = i;
        sel_task = ent_q[i];
      end
    end
  end

  assign issue_load = !bus.flush && any_elig && (!issue_valid_q || bus.issue_ready);

  // Collapse the removed slot first, then append new tasks at the resulting tail.
  always_comb begin
    shifted = ent_q;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      if (issue_load && (k >= sel_idx)) shifted[k] = ent_q[k+1];
    end
    keep    = 32'(count_q) - 32'(issue_load);
    pos0    = keep;
    pos1    = keep + 32'(bus.valid_0);
    ent_d   = shifted;
    count_d = CNT_W'(keep);
    if (enq_ready) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (bus.valid_0 && (k == pos0)) ent_d[k] = bus.task_0;
        if (bus.valid_1 && (k == pos1)) ent_d[k] = bus.task_1;
      end
      count_d = CNT_W'(keep + 32'(bus.valid_0) + 32'(bus.valid_1));
    end
    if (bus.flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q         <= '{default: '0};
      count_q       <= '0;
      issue_task_q  <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      if (bus.flush) begin
        issue_valid_q <= 1'b0;
      end else if (issue_load) begin
        issue_valid_q <= 1'b1;
        issue_task_q  <= sel_task;
      end else if (bus.issue_ready) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign bus.enq_ready   = enq_ready;
  assign bus.issue_task  = issue_task_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  issue_scheduler_if #(.DEPTH(DEPTH)) bus ();

  issue_scheduler #(
    .DEPTH    (DEPTH),
    .NUM_REGS (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: program-ordered queue, busy register set, issue slot.
  task_t       mq[$];
  logic [31:0] mbusy;
  logic        m_iv;
  task_t       m_it;
  task_t       exp_q[$];
  logic [7:0]  issued_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic task_t mk(input opcode_t op, input int rd, input int rs1, input int rs2,
                               input bit rdu, input bit r1u, input bit r2u, input int tag);
    task_t t;
    t.opcode = op;
    t.rd = 5'(rd);
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.rd_used = rdu;
    t.rs1_used = r1u;
    t.rs2_used = r2u;
    t.tag = 8'(tag);
    return t;
  endfunction

  function automatic logic [31:0] rmask(input task_t t);
    logic [31:0] m = '0;
    if (t.rs1_used) m[t.rs1] = 1'b1;
    if (t.rs2_used) m[t.rs2] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] wmask(input task_t t);
    logic [31:0] m = '0;
    if (t.rd_used) m[t.rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit mem_op(input task_t t);
    return (t.opcode == OpLoad) || (t.opcode == OpStore);
  endfunction

  function automatic bit m_elig(input int i);
    logic [31:0] r, w;
    r = rmask(mq[i]);
    w = wmask(mq[i]);
    if (((r | w) & mbusy) != 0) return 0;
    for (int j = 0; j < i; j++) begin
      if ((wmask(mq[j]) & (r | w)) != 0) return 0;
      if ((rmask(mq[j]) & w) != 0) return 0;
      if (mem_op(mq[j]) && mem_op(mq[i])) return 0;
    end
    return 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mbusy = '0;
    m_iv = 1'b0;
    m_it = '0;
  endtask

  task automatic model_step(input task_t t0, input bit v0, input task_t t1, input bit v1,
                            input bit ir, input bit wbv, input int wba, input bit fl);
    int idx;
    logic [31:0] nb;
    bit enq_ok;
    if (fl) begin
      mq.delete();
      exp_q.delete();
      mbusy = '0;
      m_iv = 1'b0;
      return;
    end
    enq_ok = (mq.size() <= DEPTH - 2);
    idx = -1;
    if (!m_iv || ir) begin
      for (int i = 0; i < mq.size(); i++) if (idx < 0 && m_elig(i)) idx = i;
    end
    nb = mbusy;
    if (wbv) nb[wba] = 1'b0;
    if (idx >= 0) begin
      m_it = mq[idx];
      m_iv = 1'b1;
      exp_q.push_back(mq[idx]);
      nb = nb | wmask(mq[idx]);
      mq.delete(idx);
    end else if (ir) begin
      m_iv = 1'b0;
    end
    mbusy = nb;
    if (enq_ok) begin
      if (v0) mq.push_back(t0);
      if (v1) mq.push_back(t1);
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("enq_ready", 64'(bus.enq_ready), 64'(mq.size() <= DEPTH - 2));
    chk("issue_valid", 64'(bus.issue_valid), 64'(m_iv));
    if (m_iv) chk("issue_task", 64'(bus.issue_task), 64'(m_it));
  endtask

  // One clock: drive at posedge+1, advance the model at the edge, compare at edge+1.
  task automatic cycle(input task_t t0, input bit v0, input task_t t1, input bit v1,
                       input bit ir, input bit wbv, input int wba, input bit fl);
    bus.task_0 = t0;
    bus.valid_0 = v0;
    bus.task_1 = t1;
    bus.valid_1 = v1;
    bus.issue_ready = ir;
    bus.wb_valid = wbv;
    bus.wb_rd_addr = 5'(wba);
    bus.flush = fl;
    @(posedge clk);
    model_step(t0, v0, t1, v1, ir, wbv, wba, fl);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit ir);
    for (int k = 0; k < n; k++) cycle('0, 0, '0, 0, ir, 0, 0, 0);
  endtask

  task automatic do_flush();
    cycle('0, 0, '0, 0, 0, 0, 0, 1);
    issued_log.delete();
  endtask

  // Monitor: a transfer happens on the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL issue_pop: DUT offered tag %0d with nothing expected", bus.issue_task.tag);
      end else begin
        chk("issued_task", 64'(bus.issue_task), 64'(exp_q.pop_front()));
        issued_log.push_back(bus.issue_task.tag);
      end
    end
  end

  function automatic task_t rand_task(input int tag);
    opcode_t ops[5] = '{OpAlu, OpAluImm, OpLoad, OpStore, OpBranch};
    return mk(ops[$urandom_range(0, 4)], $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), tag);
  endfunction

  initial begin
    task_t a, b;
    rst_n = 1'b0;
    bus.task_0 = '0;
    bus.task_1 = '0;
    bus.valid_0 = 1'b0;
    bus.valid_1 = 1'b0;
    bus.issue_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd_addr = '0;
    bus.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_issue_task", 64'(bus.issue_task), 64'(0));
    rst_n = 1'b1;

    // 1: async reset mid-stream with five queued entries
    for (int p = 0; p < 3; p++)
      cycle(mk(OpAluImm, 20 + 2 * p, 0, 0, 1, 1, 0, 100 + 2 * p), 1,
            mk(OpAluImm, 21 + 2 * p, 0, 0, 1, 1, 0, 101 + 2 * p), 1, 0, 0, 0, 0);
    chk("t1_count_before", 64'(bus.count), 64'(5));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_count", 64'(bus.count), 64'(0));
    chk("t1_issue_valid", 64'(bus.issue_valid), 64'(0));
    chk("t1_enq_ready", 64'(bus.enq_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2: two independent addi issue on consecutive cycles
    issued_log.delete();
    cycle(mk(OpAluImm, 1, 0, 0, 1, 1, 0, 1), 1, mk(OpAluImm, 2, 0, 0, 1, 1, 0, 2), 1, 1, 0, 0, 0);
    idle(1, 1);
    chk("t2_first_tag", 64'(bus.issue_task.tag), 64'(1));
    idle(1, 1);
    chk("t2_second_tag", 64'(bus.issue_task.tag), 64'(2));
    idle(2, 1);

    // 3: RAW on x3 lets the younger addi x5 overtake sub
    do_flush();
    cycle(mk(OpAlu, 3, 1, 2, 1, 1, 1, 30), 1, '0, 0, 1, 0, 0, 0);
    idle(1, 1);
    chk("t3_add_tag", 64'(bus.issue_task.tag), 64'(30));
    cycle(mk(OpAlu, 4, 3, 1, 1, 1, 1, 31), 1, mk(OpAluImm, 5, 0, 0, 1, 1, 0, 32), 1, 1, 0, 0, 0);
    idle(1, 1);
    chk("t3_addi_first", 64'(bus.issue_task.tag), 64'(32));
    idle(3, 1);
    chk("t3_sub_held", 64'(bus.issue_valid), 64'(0));
    cycle('0, 0, '0, 0, 1, 1, 3, 0);
    idle(1, 1);
    chk("t3_sub_after_wb", 64'(bus.issue_task.tag), 64'(31));
    chk("t3_sub_valid", 64'(bus.issue_valid), 64'(1));
    idle(2, 1);

    // 4: store waits behind a load blocked on its base register
    do_flush();
    cycle(mk(OpAluImm, 7, 0, 0, 1, 1, 0, 40), 1, '0, 0, 1, 0, 0, 0);
    idle(1, 1);
    cycle(mk(OpLoad, 6, 7, 0, 1, 1, 0, 41), 1, mk(OpStore, 0, 9, 8, 0, 1, 1, 42), 1, 1, 0, 0, 0);
    idle(4, 1);
    chk("t4_mem_held", 64'(bus.issue_valid), 64'(0));
    chk("t4_queue", 64'(bus.count), 64'(2));
    cycle('0, 0, '0, 0, 1, 1, 7, 0);
    idle(1, 1);
    chk("t4_load_first", 64'(bus.issue_task.tag), 64'(41));
    idle(1, 1);
    chk("t4_store_next", 64'(bus.issue_task.tag), 64'(42));
    idle(2, 1);

    // 5: fill to DEPTH under backpressure
    do_flush();
    cycle(mk(OpAluImm, 1, 0, 0, 1, 1, 0, 50), 1, '0, 0, 0, 0, 0, 0);
    idle(1, 0);
    for (int p = 0; p < 4; p++)
      cycle(mk(OpAluImm, 11 + 2 * p, 0, 0, 1, 1, 0, 51 + 2 * p), 1,
            mk(OpAluImm, 12 + 2 * p, 0, 0, 1, 1, 0, 52 + 2 * p), 1, 0, 0, 0, 0);
    chk("t5_full_count", 64'(bus.count), 64'(8));
    chk("t5_full_enq_ready", 64'(bus.enq_ready), 64'(0));
    a = mk(OpAluImm, 19, 0, 0, 1, 1, 0, 59);
    b = mk(OpAluImm, 20, 0, 0, 1, 1, 0, 60);
    cycle(a, 1, b, 1, 0, 0, 0, 0);
    chk("t5_ignored_count", 64'(bus.count), 64'(8));
    chk("t5_stable_tag", 64'(bus.issue_task.tag), 64'(50));
    cycle(a, 1, b, 1, 1, 0, 0, 0);
    chk("t5_count7", 64'(bus.count), 64'(7));
    chk("t5_enq_ready7", 64'(bus.enq_ready), 64'(0));
    cycle(a, 1, b, 1, 0, 0, 0, 0);
    chk("t5_still7", 64'(bus.count), 64'(7));
    chk("t5_next_tag", 64'(bus.issue_task.tag), 64'(51));

    // 6: issue set and writeback clear of x10 together, then flush
    do_flush();
    cycle(mk(OpAluImm, 10, 0, 0, 1, 1, 0, 60), 1, '0, 0, 1, 0, 0, 0);
    cycle(mk(OpAlu, 11, 10, 0, 1, 1, 1, 61), 1, '0, 0, 1, 1, 10, 0);
    idle(3, 1);
    chk("t6_reader_blocked", 64'(bus.issue_valid), 64'(0));
    chk("t6_reader_queued", 64'(bus.count), 64'(1));
    do_flush();
    chk("t6_flush_count", 64'(bus.count), 64'(0));
    chk("t6_flush_valid", 64'(bus.issue_valid), 64'(0));
    cycle(mk(OpAlu, 11, 10, 0, 1, 1, 1, 61), 1, '0, 0, 1, 0, 0, 0);
    idle(1, 1);
    chk("t6_busy_cleared", 64'(bus.issue_task.tag), 64'(61));
    idle(2, 1);

    // Random traffic against the model
    do_flush();
    for (int c = 0; c < 3000; c++) begin
      cycle(rand_task(2 * c), ($urandom_range(0, 3) != 0), rand_task(2 * c + 1),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4), $urandom_range(0, 7), ($urandom_range(0, 99) == 0));
    end
    idle(4, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
